// File: rtl/brew_sequencer.sv
// Coffee-maker sequencer: IDLE -> HEAT -> BREW -> DONE with second countdowns driven by clk_1Hz ticks.
// Define BREW_WATER_SENSE_EN to enable the water-level fault path and the ERROR state.
module brew_sequencer #(
  parameter int HEAT_SECS   = 30,
  parameter int BREW_S_SECS = 20,
  parameter int BREW_M_SECS = 40,
  parameter int BREW_L_SECS = 60,
  parameter int DONE_SECS   = 5
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       start,
  input  logic       cancel,
  input  logic [1:0] sel_size,
  input  logic       water_ok,
  output logic       heater_on,
  output logic       pump_on,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state,
  output logic [7:0] secs_left
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAT  = 3'd1,
    BREW  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  // A zero duration would never see secs_left==1, so it is promoted to one tick.
  function automatic logic [7:0] clamp_secs(input int v);
    if (v < 1)        return 8'd1;
    else if (v > 255) return 8'd255;
    else              return 8'(v);
  endfunction

  localparam logic [7:0] HEAT_LEN   = clamp_secs(HEAT_SECS);
  localparam logic [7:0] BREW_S_LEN = clamp_secs(BREW_S_SECS);
  localparam logic [7:0] BREW_M_LEN = clamp_secs(BREW_M_SECS);
  localparam logic [7:0] BREW_L_LEN = clamp_secs(BREW_L_SECS);
  localparam logic [7:0] DONE_LEN   = clamp_secs(DONE_SECS);

  logic       s1, s2, s3;
  logic       tick;
  state_t     state_q, state_d;
  logic [7:0] secs_q, secs_d;
  logic [7:0] brew_len_q, brew_len_d;
  logic [7:0] size_len;
  logic       start_ok;
  logic       water_fault;

  assign tick = s2 & ~s3;

`ifdef BREW_WATER_SENSE_EN
  assign start_ok    = start & ~cancel & (sel_size != 2'd3) & water_ok;
  assign water_fault = ~water_ok;
`else
  logic unused_water;
  assign unused_water = water_ok;
  assign start_ok     = start & ~cancel & (sel_size != 2'd3);
  assign water_fault  = 1'b0;
`endif

  always_comb begin
    case (sel_size)
      2'd0:    size_len = BREW_S_LEN;
      2'd1:    size_len = BREW_M_LEN;
      default: size_len = BREW_L_LEN;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    secs_d     = secs_q;
    brew_len_d = brew_len_q;
    case (state_q)
      IDLE: begin
        secs_d = 8'd0;
        if (start_ok) begin
          state_d    = HEAT;
          secs_d     = HEAT_LEN;
          brew_len_d = size_len;
        end
      end
      HEAT, BREW, DONE: begin
        if (cancel) begin
          state_d = IDLE;
          secs_d  = 8'd0;
        end else if (water_fault && state_q != DONE) begin
          state_d = ERROR;
          secs_d  = 8'd0;
        end else if (tick) begin
          if (secs_q > 8'd1) begin
            secs_d = secs_q - 8'd1;
          end else if (state_q == HEAT) begin
            state_d = BREW;
            secs_d  = brew_len_q;
          end else if (state_q == BREW) begin
            state_d = DONE;
            secs_d  = DONE_LEN;
          end else begin
            state_d = IDLE;
            secs_d  = 8'd0;
          end
        end
      end
      ERROR: begin
        secs_d = 8'd0;
        if (cancel) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        secs_d  = 8'd0;
      end
    endcase
  end

  // Flags are decoded from the next state so they line up with state/secs_left.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state_q    <= IDLE;
      secs_q     <= 8'd0;
      brew_len_q <= 8'd0;
      heater_on  <= 1'b0;
      pump_on    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      s1         <= clk_1Hz;
      s2         <= s1;
      s3         <= s2;
      state_q    <= state_d;
      secs_q     <= secs_d;
      brew_len_q <= brew_len_d;
      heater_on  <= (state_d == HEAT) || (state_d == BREW);
      pump_on    <= (state_d == BREW);
      busy       <= (state_d == HEAT) || (state_d == BREW);
      done       <= (state_d == DONE);
    end
  end

`ifdef BREW_WATER_SENSE_EN
  always_ff @(posedge clk_100MHz) begin
    if (rst) err <= 1'b0;
    else     err <= (state_d == ERROR);
  end
`else
  assign err = 1'b0;
`endif

  assign state     = state_q;
  assign secs_left = secs_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer: a vector table for the main sequence plus
// hand-written sequences for tick/cancel/start/reset coincidences.
module tb_brew_sequencer;

  logic       clk_100MHz = 1'b0;
  logic       rst;
  logic       clk_1Hz;
  logic       start;
  logic       cancel;
  logic [1:0] sel_size;
  logic       water_ok;
  logic       heater_on, pump_on, busy, done, err;
  logic [2:0] state;
  logic [7:0] secs_left;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string      name;
    logic       start;
    logic       cancel;
    logic [1:0] sel;
    int         pulses;
    logic [2:0] exp_state;
    logic [7:0] exp_secs;
    logic       exp_heater;
    logic       exp_pump;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs[13];

  brew_sequencer dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .clk_1Hz    (clk_1Hz),
    .start      (start),
    .cancel     (cancel),
    .sel_size   (sel_size),
    .water_ok   (water_ok),
    .heater_on  (heater_on),
    .pump_on    (pump_on),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state      (state),
    .secs_left  (secs_left)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic checkOutput(input string name, input logic [2:0] e_state, input logic [7:0] e_secs,
                             input logic e_heater, input logic e_pump, input logic e_busy,
                             input logic e_done, input logic e_err);
    logic [14:0] act, exp;
    act = {state, secs_left, heater_on, pump_on, busy, done, err};
    exp = {e_state, e_secs, e_heater, e_pump, e_busy, e_done, e_err};
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got state=%0d secs=%0d h/p/b/d/e=%b%b%b%b%b, want state=%0d secs=%0d h/p/b/d/e=%b%b%b%b%b",
                  name, state, secs_left, heater_on, pump_on, busy, done, err,
                  e_state, e_secs, e_heater, e_pump, e_busy, e_done, e_err);
  endtask

  // One clk_1Hz rising edge, held long enough for the tick to land, then low again.
  task automatic pulse1Hz();
    clk_1Hz = 1'b1;
    repeat (4) @(negedge clk_100MHz);
    clk_1Hz = 1'b0;
    repeat (4) @(negedge clk_100MHz);
  endtask

  task automatic applyStimulus(input vec_t v);
    start    = v.start;
    cancel   = v.cancel;
    sel_size = v.sel;
    @(negedge clk_100MHz);
    start  = 1'b0;
    cancel = 1'b0;
    for (int p = 0; p < v.pulses; p++) pulse1Hz();
  endtask

  // Raise clk_1Hz and stop on the cycle where the derived tick is live.
  task automatic riseToTick();
    clk_1Hz = 1'b1;
    repeat (2) @(negedge clk_100MHz);
  endtask

  initial begin
    vecs[0]  = '{"start_medium",   1, 0, 2'd1,  0, 3'd1, 8'd30, 1, 0, 1, 0};
    vecs[1]  = '{"heat_first_tick",0, 0, 2'd1,  1, 3'd1, 8'd29, 1, 0, 1, 0};
    vecs[2]  = '{"heat_to_brew",   0, 0, 2'd1, 29, 3'd2, 8'd40, 1, 1, 1, 0};
    vecs[3]  = '{"start_in_brew",  1, 0, 2'd2,  0, 3'd2, 8'd40, 1, 1, 1, 0};
    vecs[4]  = '{"brew_last_sec",  0, 0, 2'd0, 39, 3'd2, 8'd1,  1, 1, 1, 0};
    vecs[5]  = '{"brew_to_done",   0, 0, 2'd0,  1, 3'd3, 8'd5,  0, 0, 0, 1};
    vecs[6]  = '{"done_to_idle",   0, 0, 2'd0,  5, 3'd0, 8'd0,  0, 0, 0, 0};
    vecs[7]  = '{"start_size3",    1, 0, 2'd3,  3, 3'd0, 8'd0,  0, 0, 0, 0};
    vecs[8]  = '{"start_cancel",   1, 1, 2'd0,  0, 3'd0, 8'd0,  0, 0, 0, 0};
    vecs[9]  = '{"start_small",    1, 0, 2'd0,  0, 3'd1, 8'd30, 1, 0, 1, 0};
    vecs[10] = '{"small_brew",     0, 0, 2'd2, 30, 3'd2, 8'd20, 1, 1, 1, 0};
    vecs[11] = '{"small_brew_12",  0, 0, 2'd2,  8, 3'd2, 8'd12, 1, 1, 1, 0};
    vecs[12] = '{"cancel_brew",    0, 1, 2'd0,  0, 3'd0, 8'd0,  0, 0, 0, 0};

    rst = 1'b1; clk_1Hz = 1'b0; start = 1'b0; cancel = 1'b0; sel_size = 2'd0; water_ok = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    checkOutput("reset_state", 3'd0, 8'd0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk_100MHz);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].exp_state, vecs[i].exp_secs, vecs[i].exp_heater,
                  vecs[i].exp_pump, vecs[i].exp_busy, vecs[i].exp_done, 1'b0);
    end

    // Cancel coincident with a tick in BREW at 12 seconds left.
    applyStimulus('{"", 1, 0, 2'd2, 30, 3'd0, 8'd0, 0, 0, 0, 0});
    checkOutput("large_brew", 3'd2, 8'd60, 1, 1, 1, 0, 0);
    for (int p = 0; p < 48; p++) pulse1Hz();
    checkOutput("large_brew_12", 3'd2, 8'd12, 1, 1, 1, 0, 0);
    riseToTick();
    cancel = 1'b1;
    @(negedge clk_100MHz);
    cancel = 1'b0;
    checkOutput("cancel_on_tick", 3'd0, 8'd0, 0, 0, 0, 0, 0);
    clk_1Hz = 1'b0;
    repeat (4) @(negedge clk_100MHz);
    checkOutput("idle_after_cancel", 3'd0, 8'd0, 0, 0, 0, 0, 0);

    // A tick in the start cycle must not shorten HEAT.
    riseToTick();
    start = 1'b1; sel_size = 2'd0;
    @(negedge clk_100MHz);
    start = 1'b0;
    checkOutput("start_on_tick", 3'd1, 8'd30, 1, 0, 1, 0, 0);
    repeat (3) @(negedge clk_100MHz);
    clk_1Hz = 1'b0;
    repeat (4) @(negedge clk_100MHz);
    checkOutput("start_tick_ignored", 3'd1, 8'd30, 1, 0, 1, 0, 0);

`ifdef BREW_WATER_SENSE_EN
    water_ok = 1'b0;
    @(negedge clk_100MHz);
    checkOutput("water_fault", 3'd4, 8'd0, 0, 0, 0, 0, 1);
    start = 1'b1; sel_size = 2'd1;
    @(negedge clk_100MHz);
    start = 1'b0;
    checkOutput("error_ignores_start", 3'd4, 8'd0, 0, 0, 0, 0, 1);
    pulse1Hz();
    checkOutput("error_ignores_tick", 3'd4, 8'd0, 0, 0, 0, 0, 1);
    cancel = 1'b1;
    @(negedge clk_100MHz);
    cancel = 1'b0;
    checkOutput("error_cancel", 3'd0, 8'd0, 0, 0, 0, 0, 0);
    start = 1'b1;
    @(negedge clk_100MHz);
    start = 1'b0;
    checkOutput("dry_start_blocked", 3'd0, 8'd0, 0, 0, 0, 0, 0);
    water_ok = 1'b1;
`else
    water_ok = 1'b0;
    pulse1Hz();
    checkOutput("water_ignored", 3'd1, 8'd29, 1, 0, 1, 0, 0);
    water_ok = 1'b1;
    cancel = 1'b1;
    @(negedge clk_100MHz);
    cancel = 1'b0;
    checkOutput("cancel_heat", 3'd0, 8'd0, 0, 0, 0, 0, 0);
`endif

    // Reset mid-BREW, coincident with a tick and a start request.
    applyStimulus('{"", 1, 0, 2'd0, 30, 3'd0, 8'd0, 0, 0, 0, 0});
    checkOutput("brew_before_rst", 3'd2, 8'd20, 1, 1, 1, 0, 0);
    riseToTick();
    rst = 1'b1; start = 1'b1;
    @(negedge clk_100MHz);
    rst = 1'b0; start = 1'b0;
    checkOutput("rst_mid_brew", 3'd0, 8'd0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk_100MHz);
    checkOutput("edge_after_rst", 3'd0, 8'd0, 0, 0, 0, 0, 0);
    clk_1Hz = 1'b0;
    repeat (4) @(negedge clk_100MHz);

    // Restart after reset still sequences normally.
    applyStimulus('{"", 1, 0, 2'd2, 1, 3'd0, 8'd0, 0, 0, 0, 0});
    checkOutput("restart_after_rst", 3'd1, 8'd29, 1, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
